windowed_register_file: RTL
===========================

# windowed_register_file

Parametrised SPARC-style windowed register file for the processor datapath: 8 global registers plus `NWIN` overlapping 24-register windows, with a current window pointer (CWP), a window invalid mask (WIM), and save/restore handling that detects window overflow and underflow. It supplies ALU operand ports A/B and takes its write data from the ALU result bus. It is the generalised successor of the fixed four-window register file, adding configurable window count and data width, on-chip CWP/WIM state, and trap detection.

## Interface
- `WIDTH`, 32, data width of every register and port.
- `NWIN`, 4, number of windows; a power of two from 2 to 32.
- `CWPW`, `$clog2(NWIN)`, CWP width; derived, not overridden.

- `Clk` in 1: clock; all state updates on the rising edge.
- `Clr` in 1: reset; synchronous, active-high.
- `RA` in 5: architectural address for read port A.
- `RB` in 5: architectural address for read port B.
- `RC` in 5: architectural write address.
- `DataIn` in WIDTH: write data from the ALU result bus.
- `Ld` in 1: write enable for `RC`.
- `Save` in 1: save request; decrements CWP.
- `Restore` in 1: restore request; increments CWP.
- `WimIn` in NWIN: new WIM value.
- `WimLd` in 1: load enable for WIM.
- `PortA` out WIDTH: read data for `RA`.
- `PortB` out WIDTH: read data for `RB`.
- `Cwp` out CWPW: current window pointer.
- `Wim` out NWIN: current window invalid mask.
- `WOvf` out 1: window-overflow trap pulse.
- `WUnf` out 1: window-underflow trap pulse.

## Operation
- Physical storage is 8 global registers plus NWIN×16 windowed registers. `N16` = NWIN×16.
- Address mapping, with `w` = CWP and all windowed indices taken mod `N16`:
  - r0–r7 map to globals 0–7.
  - outs r8–r15 map to `16w+(r−8)`.
  - locals r16–r23 map to `16w+8+(r−16)`.
  - ins r24–r31 map to `16(w+1)+(r−24)`.
  - Result: the outs of window `w` are the ins of window `w−1`.
- r0 reads as 0. Writes to r0 are discarded.
- Reads are combinational from RA/RB and the current CWP.
- Write: when `Ld`=1 and `RC`≠0, the register addressed by `RC` under the current (pre-edge) CWP is loaded with `DataIn`.
- Save, when `Save`=1 and `Restore`=0:
  - If `Wim[(CWP−1) mod NWIN]`=1: CWP is unchanged and `WOvf` pulses.
  - Otherwise: CWP ← CWP−1 (mod NWIN).
- Restore, when `Restore`=1 and `Save`=0:
  - If `Wim[(CWP+1) mod NWIN]`=1: CWP is unchanged and `WUnf` pulses.
  - Otherwise: CWP ← CWP+1 (mod NWIN).
- `Save` and `Restore` asserted together is a no-op: no CWP change and no trap pulse.
- `WimLd`=1: WIM ← `WimIn`. A Save/Restore in the same cycle checks the old WIM.
- Wrap-around: CWP 0 with Save goes to NWIN−1; CWP NWIN−1 with Restore goes to 0.
- Reset (`Clr`=1), which overrides every other input including mid-sequence Save/Restore/Ld:
  - all registers ← 0;
  - CWP ← 0;
  - WIM ← 0;
  - `WOvf` = `WUnf` = 0.
  - After reset, `PortA`=`PortB`=0, `Cwp`=0, `Wim`=0.

## Timing
- Read latency is 0 cycles (combinational from address and CWP).
- A write is visible on the read ports in the cycle after its edge, unless bypass is compiled in.
- CWP changes at the edge that samples Save/Restore. The next cycle's reads use the new window.
- A write issued in the same cycle as Save/Restore targets the old window.
- `WOvf` and `WUnf` are registered. Each is high for exactly one cycle, the cycle after the offending request edge.
- Back-to-back Save requests each evaluate against the CWP updated by the previous edge.

## Configuration
- `WRF_BYPASS_EN`:
  - **Defined:** when `Ld`=1, `RC`≠0, and the physical index of `RC` equals that of `RA` or `RB` (both under the current CWP), the matching port outputs `DataIn` combinationally in the same cycle.
  - **Undefined:** no forwarding; ports show the stored value until the next cycle.
  - r0 is never bypassed in either case.

## Test plan
- **Reset and r0:**
  - Stimulus: `Clr`=1 for one edge, then write 0xDEADBEEF to r0.
  - Required: `PortA`(RA=0)=0, `Cwp`=0, `Wim`=0.
- **Window overlap:**
  - Stimulus: at CWP=0 write 0x11 to r8; Save; read RA=24.
  - Required: `Cwp`=NWIN−1 and `PortA`=0x11.
- **Locals private:**
  - Stimulus: write 0x22 to r16 at CWP=0; Save; read r16.
  - Required: 0, then after Restore 0x22.
- **Overflow:**
  - Stimulus: NWIN=4, WIM=4'b1000, CWP=0, Save.
  - Required: `Cwp` stays 0 and `WOvf`=1 for one cycle. With WIM=4'b0010, Restore gives `WUnf`=1.
- **Simultaneous events:**
  - Save+Restore together: no change, no pulse.
  - Save with `WimLd` setting the target bit: Save proceeds using the old WIM.
  - `Clr` with Save: `Cwp`=0.
- **Bypass:**
  - Stimulus: `Ld`=1, `RC`=RA=5, `DataIn`=0x5A.
  - Required: `PortA`=0x5A the same cycle with `WRF_BYPASS_EN` defined, and the old value without it.

Source files
------------

// File: rtl/windowed_register_file.sv
// windowed_register_file: SPARC-style windowed register file.
// 8 globals plus NWIN overlapping 24-register windows, with a current window
// pointer, a window invalid mask and overflow/underflow trap pulses on
// save/restore. Optional compile-time macro WRF_BYPASS_EN forwards write data
// to a read port that addresses the register being written in the same cycle.
module windowed_register_file #(
    parameter int WIDTH = 32,
    parameter int NWIN  = 4,
    localparam int CWPW = $clog2(NWIN)
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic [4:0]       RA,
    input  logic [4:0]       RB,
    input  logic [4:0]       RC,
    input  logic [WIDTH-1:0] DataIn,
    input  logic             Ld,
    input  logic             Save,
    input  logic             Restore,
    input  logic [NWIN-1:0]  WimIn,
    input  logic             WimLd,
    output logic [WIDTH-1:0] PortA,
    output logic [WIDTH-1:0] PortB,
    output logic [CWPW-1:0]  Cwp,
    output logic [NWIN-1:0]  Wim,
    output logic             WOvf,
    output logic             WUnf
);

    localparam int N16 = NWIN * 16;
    // Windowed index = {window, local bit, register within group}.
    localparam int WIW = CWPW + 4;

    logic [WIDTH-1:0] glob_q [8];
    logic [WIDTH-1:0] glob_d [8];
    logic [WIDTH-1:0] win_q  [N16];
    logic [WIDTH-1:0] win_d  [N16];

    logic [CWPW-1:0] cwp_q, cwp_d;
    logic [NWIN-1:0] wim_q, wim_d;
    logic            wovf_q, wovf_d;
    logic            wunf_q, wunf_d;

    logic [WIW-1:0]  ra_idx, rb_idx, rc_idx;
    logic            wr_en;
    logic [CWPW-1:0] cwp_dec, cwp_inc;

    // Ins of window w live in the outs group of window w+1; the CWP field
    // wraps naturally because NWIN is a power of two.
    function automatic logic [WIW-1:0] win_index(input logic [4:0] r,
                                                 input logic [CWPW-1:0] w);
        logic [CWPW-1:0] ws;
        ws = (r[4:3] == 2'b11) ? w + CWPW'(1) : w;
        return {ws, (r[4:3] == 2'b10), r[2:0]};
    endfunction

    assign ra_idx  = win_index(RA, cwp_q);
    assign rb_idx  = win_index(RB, cwp_q);
    assign rc_idx  = win_index(RC, cwp_q);
    assign wr_en   = Ld && (RC != 5'd0);
    assign cwp_dec = cwp_q - CWPW'(1);
    assign cwp_inc = cwp_q + CWPW'(1);

`ifdef WRF_BYPASS_EN
    // Physical identity of an address: globals and windowed registers are
    // tagged apart so e.g. r1 never matches windowed slot 1.
    function automatic logic [WIW:0] phys_key(input logic [4:0] r,
                                              input logic [WIW-1:0] idx);
        if (r[4:3] == 2'b00)
            return {1'b0, {(WIW-3){1'b0}}, r[2:0]};
        return {1'b1, idx};
    endfunction

    logic byp_a, byp_b;
    assign byp_a = wr_en && (phys_key(RC, rc_idx) == phys_key(RA, ra_idx));
    assign byp_b = wr_en && (phys_key(RC, rc_idx) == phys_key(RB, rb_idx));
`endif

    // Next-state of the storage arrays: at most one register written per cycle.
    always_comb begin
        glob_d = glob_q;
        win_d  = win_q;
        if (wr_en) begin
            if (RC[4:3] == 2'b00)
                glob_d[RC[2:0]] = DataIn;
            else
                win_d[rc_idx] = DataIn;
        end
    end

    // Global register flops.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            for (int i = 0; i < 8; i++) glob_q[i] <= '0;
        end else begin
            glob_q <= glob_d;
        end
    end

    generate
        for (genvar gi = 0; gi < N16; gi++) begin : g_win
            // One windowed register.
            always_ff @(posedge Clk) begin
                if (Clr) win_q[gi] <= '0;
                else     win_q[gi] <= win_d[gi];
            end
        end
    endgenerate

    // Window pointer / mask next state; the mask tested is always the old one.
    always_comb begin
        cwp_d  = cwp_q;
        wim_d  = WimLd ? WimIn : wim_q;
        wovf_d = 1'b0;
        wunf_d = 1'b0;
        if (Save && !Restore) begin
            if (wim_q[cwp_dec]) wovf_d = 1'b1;
            else                cwp_d  = cwp_dec;
        end else if (Restore && !Save) begin
            if (wim_q[cwp_inc]) wunf_d = 1'b1;
            else                cwp_d  = cwp_inc;
        end
    end

    // Window control registers and single-cycle trap pulses.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            cwp_q  <= '0;
            wim_q  <= '0;
            wovf_q <= 1'b0;
            wunf_q <= 1'b0;
        end else begin
            cwp_q  <= cwp_d;
            wim_q  <= wim_d;
            wovf_q <= wovf_d;
            wunf_q <= wunf_d;
        end
    end

    // Combinational read ports; r0 is hard zero and never forwarded.
    always_comb begin
        PortA = (RA[4:3] == 2'b00) ? glob_q[RA[2:0]] : win_q[ra_idx];
        PortB = (RB[4:3] == 2'b00) ? glob_q[RB[2:0]] : win_q[rb_idx];
`ifdef WRF_BYPASS_EN
        if (byp_a) PortA = DataIn;
        if (byp_b) PortB = DataIn;
`endif
        if (RA == 5'd0) PortA = '0;
        if (RB == 5'd0) PortB = '0;
    end

    assign Cwp  = cwp_q;
    assign Wim  = wim_q;
    assign WOvf = wovf_q;
    assign WUnf = wunf_q;

endmodule
